// File: rtl/voting_machine_param.sv
// N-candidate voting machine: debounced single-button votes, multi-press reject, lockout, saturating counts.
// Vote counted DEBOUNCE edges after the first sampled press; results and led are registered one cycle behind the counts.
module voting_machine_param #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    parameter int DEBOUNCE = 10,
    parameter int LOCKOUT  = 8,
    parameter int IDX_W    = $clog2(NUM_CAND)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mode,
    input  logic [NUM_CAND-1:0]    button,
    output logic [CNT_W-1:0]       led,
    output logic                   vote_valid,
    output logic                   vote_reject,
    output logic [IDX_W-1:0]       vote_idx,
    output logic [CNT_W+IDX_W-1:0] total_votes,
    output logic [IDX_W-1:0]       winner_idx,
    output logic                   winner_valid,
    output logic                   tie
);

    typedef enum logic [1:0] {S_IDLE, S_DEB, S_HOLD, S_LOCK} state_t;

    state_t                   r_state, w_state_nxt;
    logic [31:0]              r_dcnt, w_dcnt_nxt;
    logic [31:0]              r_lcnt, w_lcnt_nxt;
    logic [IDX_W-1:0]         r_idx, w_idx_nxt;
    logic                     w_cnt_en, w_rej;
    logic                     r_vld, r_rej;
    logic [IDX_W-1:0]         r_vote_idx;
    logic [CNT_W-1:0]         r_cnt [NUM_CAND];
    logic [CNT_W-1:0]         r_led, w_led_nxt;
    logic [CNT_W+IDX_W-1:0]   r_total, w_sum;
    logic [IDX_W-1:0]         r_winner_idx, w_max_idx;
    logic                     r_winner_vld, r_tie;
    logic [CNT_W-1:0]         w_max;
    logic [IDX_W:0]           w_nmax;
    logic [IDX_W-1:0]         w_low_idx;
    logic                     w_any, w_single;
    logic [NUM_CAND-1:0]      w_idx_onehot;

    assign w_any        = |button;
    assign w_single     = $onehot(button);
    assign w_idx_onehot = NUM_CAND'(1) << r_idx;

    always_comb begin
        w_low_idx = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (button[i]) w_low_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = r_dcnt;
        w_lcnt_nxt  = r_lcnt;
        w_idx_nxt   = r_idx;
        w_cnt_en    = 1'b0;
        w_rej       = 1'b0;
        if (mode) begin
            w_state_nxt = S_IDLE;
            w_dcnt_nxt  = '0;
            w_lcnt_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_single) begin
                        w_state_nxt = S_DEB;
                        w_idx_nxt   = w_low_idx;
                        w_dcnt_nxt  = 32'd1;
                    end else if (w_any) begin
                        w_state_nxt = S_HOLD;
                        w_rej       = 1'b1;
                    end
                end
                S_DEB: begin
                    if (button == w_idx_onehot) begin
                        if (r_dcnt >= 32'(DEBOUNCE)) begin
                            w_cnt_en    = 1'b1;
                            w_state_nxt = S_HOLD;
                        end else begin
                            w_dcnt_nxt = r_dcnt + 32'd1;
                        end
                    end else if (!w_any) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_HOLD;
                        w_rej       = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!w_any) begin
                        w_state_nxt = (LOCKOUT == 0) ? S_IDLE : S_LOCK;
                        w_lcnt_nxt  = '0;
                    end
                end
                S_LOCK: begin
                    // Buttons are ignored here; a press still held at exit restarts debounce from IDLE.
                    if (r_lcnt + 32'd1 >= 32'(LOCKOUT)) w_state_nxt = S_IDLE;
                    else                                w_lcnt_nxt  = r_lcnt + 32'd1;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_max     = '0;
        w_max_idx = '0;
        w_nmax    = '0;
        w_sum     = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            w_sum = w_sum + (CNT_W+IDX_W)'(r_cnt[i]);
            if (r_cnt[i] > w_max) begin
                w_max     = r_cnt[i];
                w_max_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_CAND; i++) begin
            if (r_cnt[i] == w_max) w_nmax = w_nmax + (IDX_W+1)'(1);
        end
    end

    always_comb begin
        w_led_nxt = r_cnt[r_vote_idx];
        if (mode) w_led_nxt = w_any ? r_cnt[w_low_idx] : r_cnt[r_winner_idx];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_dcnt       <= '0;
            r_lcnt       <= '0;
            r_idx        <= '0;
            r_vld        <= 1'b0;
            r_rej        <= 1'b0;
            r_vote_idx   <= '0;
            r_led        <= '0;
            r_total      <= '0;
            r_winner_idx <= '0;
            r_winner_vld <= 1'b0;
            r_tie        <= 1'b0;
            for (int i = 0; i < NUM_CAND; i++) r_cnt[i] <= '0;
        end else begin
            r_dcnt       <= w_dcnt_nxt;
            r_lcnt       <= w_lcnt_nxt;
            r_idx        <= w_idx_nxt;
            r_vld        <= w_cnt_en;
            r_rej        <= w_rej;
            r_led        <= w_led_nxt;
            r_total      <= w_sum;
            r_winner_idx <= w_max_idx;
            r_winner_vld <= (w_max != '0) && (w_nmax == (IDX_W+1)'(1));
            r_tie        <= (w_max != '0) && (w_nmax >= (IDX_W+1)'(2));
            if (w_cnt_en) begin
                r_vote_idx <= r_idx;
                if (r_cnt[r_idx] != '1) r_cnt[r_idx] <= r_cnt[r_idx] + CNT_W'(1);
            end
        end
    end

    assign led          = r_led;
    assign vote_valid   = r_vld;
    assign vote_reject  = r_rej;
    assign vote_idx     = r_vote_idx;
    assign total_votes  = r_total;
    assign winner_idx   = r_winner_idx;
    assign winner_valid = r_winner_vld;
    assign tie          = r_tie;

endmodule

// File: tb/tb_voting_machine_param.sv
// Scoreboard bench for voting_machine_param: expected vote indices queued at press time, popped on vote_valid.
module tb_voting_machine_param;

    localparam int NC = 4;
    localparam int CW = 4;
    localparam int DB = 4;
    localparam int LO = 3;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            mode = 1'b0;
    logic [NC-1:0]   button = '0;
    logic [CW-1:0]   led;
    logic            vote_valid;
    logic            vote_reject;
    logic [IW-1:0]   vote_idx;
    logic [CW+IW-1:0] total_votes;
    logic [IW-1:0]   winner_idx;
    logic            winner_valid;
    logic            tie;

    voting_machine_param #(
        .NUM_CAND(NC), .CNT_W(CW), .DEBOUNCE(DB), .LOCKOUT(LO)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .button(button),
        .led(led), .vote_valid(vote_valid), .vote_reject(vote_reject),
        .vote_idx(vote_idx), .total_votes(total_votes), .winner_idx(winner_idx),
        .winner_valid(winner_valid), .tie(tie)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];
    int exp_cnt[NC];
    int vld_seen = 0;
    int rej_seen = 0;
    int sb_exp;

    always @(negedge clk) begin
        if (vote_valid) begin
            vld_seen++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected_vote got vote_idx=%0d, expected no vote", vote_idx);
            end else begin
                sb_exp = exp_q.pop_front();
                if (vote_idx !== IW'(sb_exp))
                    $display("FAIL sb_vote_idx got %0d, expected %0d", vote_idx, sb_exp);
                else
                    n_pass++;
            end
        end
        if (vote_reject) rej_seen++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Drive a pattern for 'hold' cycles, then release and idle for 'rel_wait' cycles.
    task automatic press(input logic [NC-1:0] pat, input int hold, input int rel_wait,
                         output int nv, output int first);
        button = pat;
        nv = 0;
        first = -1;
        for (int k = 1; k <= hold; k++) begin
            @(negedge clk);
            if (vote_valid) begin
                nv++;
                if (first < 0) first = k;
            end
        end
        button = '0;
        repeat (rel_wait) @(negedge clk);
    endtask

    task automatic expect_vote(input int idx);
        exp_q.push_back(idx);
        if (exp_cnt[idx] < (1 << CW) - 1) exp_cnt[idx]++;
    endtask

    task automatic test_reset;
        reset = 1'b0; mode = 1'b0; button = '0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (led !== '0) $display("FAIL reset_led got %0d, expected 0", led); else n_pass++;
        n_checks++;
        if ({vote_valid, vote_reject} !== 2'b00)
            $display("FAIL reset_pulses got %b, expected 00", {vote_valid, vote_reject});
        else n_pass++;
        n_checks++;
        if ({vote_idx, total_votes, winner_idx} !== '0)
            $display("FAIL reset_idx_total got %h, expected 0", {vote_idx, total_votes, winner_idx});
        else n_pass++;
        n_checks++;
        if ({winner_valid, tie} !== 2'b00)
            $display("FAIL reset_winner_tie got %b, expected 00", {winner_valid, tie});
        else n_pass++;
    endtask

    task automatic test_clean_votes;
        int nv, first, v0;
        v0 = vld_seen;
        for (int p = 0; p < 2; p++) begin
            expect_vote(0);
            press(4'b0001, 20, 6, nv, first);
            n_checks++;
            if (nv !== 1) $display("FAIL clean_once got %0d pulses, expected 1", nv); else n_pass++;
            n_checks++;
            if (first !== DB + 1) $display("FAIL clean_latency got %0d, expected %0d", first, DB + 1);
            else n_pass++;
        end
        n_checks++;
        if (vld_seen - v0 !== 2) $display("FAIL clean_pulses got %0d, expected 2", vld_seen - v0);
        else n_pass++;
        n_checks++;
        if (led !== 4'd2) $display("FAIL clean_led got %0d, expected 2", led); else n_pass++;
        n_checks++;
        if ({winner_idx, winner_valid, tie} !== {2'd0, 1'b1, 1'b0})
            $display("FAIL clean_winner got idx=%0d v=%b tie=%b, expected 0 1 0", winner_idx, winner_valid, tie);
        else n_pass++;
        n_checks++;
        if (total_votes !== 6'd2) $display("FAIL clean_total got %0d, expected 2", total_votes); else n_pass++;
    endtask

    task automatic test_glitch;
        int nv, first, v0;
        v0 = vld_seen;
        press(4'b0010, 2, 8, nv, first);
        n_checks++;
        if (vld_seen !== v0) $display("FAIL glitch_no_vote got %0d pulses, expected 0", vld_seen - v0);
        else n_pass++;
        n_checks++;
        if (total_votes !== 6'd2) $display("FAIL glitch_total got %0d, expected 2", total_votes); else n_pass++;
    endtask

    task automatic test_reject;
        int nv, first, v0, r0;
        v0 = vld_seen;
        r0 = rej_seen;
        press(4'b0110, 6, 6, nv, first);
        n_checks++;
        if (rej_seen - r0 !== 1) $display("FAIL reject_pulse got %0d, expected 1", rej_seen - r0);
        else n_pass++;
        n_checks++;
        if (vld_seen !== v0) $display("FAIL reject_no_vote got %0d pulses, expected 0", vld_seen - v0);
        else n_pass++;
        n_checks++;
        if (total_votes !== 6'd2) $display("FAIL reject_total got %0d, expected 2", total_votes); else n_pass++;
    endtask

    task automatic test_tie;
        int nv, first;
        for (int p = 0; p < 2; p++) begin
            expect_vote(2);
            press(4'b0100, 8, 6, nv, first);
        end
        n_checks++;
        if ({tie, winner_valid} !== 2'b10)
            $display("FAIL tie_flags got tie=%b v=%b, expected 1 0", tie, winner_valid);
        else n_pass++;
        n_checks++;
        if (winner_idx !== 2'd0) $display("FAIL tie_winner_idx got %0d, expected 0", winner_idx); else n_pass++;
        n_checks++;
        if (total_votes !== 6'd4) $display("FAIL tie_total got %0d, expected 4", total_votes); else n_pass++;
    endtask

    task automatic test_display;
        int v0;
        v0 = vld_seen;
        mode = 1'b1;
        button = 4'b0100;
        @(negedge clk);
        n_checks++;
        if (led !== CW'(exp_cnt[2])) $display("FAIL disp_btn2 got %0d, expected %0d", led, exp_cnt[2]);
        else n_pass++;
        button = 4'b0010;
        @(negedge clk);
        n_checks++;
        if (led !== CW'(exp_cnt[1])) $display("FAIL disp_btn1 got %0d, expected %0d", led, exp_cnt[1]);
        else n_pass++;
        button = 4'b1000;
        repeat (8) @(negedge clk);
        n_checks++;
        if (vld_seen !== v0) $display("FAIL disp_no_vote got %0d pulses, expected 0", vld_seen - v0);
        else n_pass++;
        button = '0;
        @(negedge clk);
        n_checks++;
        if (led !== CW'(exp_cnt[0])) $display("FAIL disp_winner got %0d, expected %0d", led, exp_cnt[0]);
        else n_pass++;
        mode = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_saturate;
        int nv, first, v0;
        v0 = vld_seen;
        for (int p = 0; p < 17; p++) begin
            expect_vote(3);
            press(4'b1000, 6, 6, nv, first);
        end
        n_checks++;
        if (vld_seen - v0 !== 17) $display("FAIL sat_pulses got %0d, expected 17", vld_seen - v0);
        else n_pass++;
        n_checks++;
        if (led !== 4'd15) $display("FAIL sat_led got %0d, expected 15", led); else n_pass++;
        n_checks++;
        if ({winner_idx, winner_valid, tie} !== {2'd3, 1'b1, 1'b0})
            $display("FAIL sat_winner got idx=%0d v=%b tie=%b, expected 3 1 0", winner_idx, winner_valid, tie);
        else n_pass++;
        n_checks++;
        if (total_votes !== 6'd19) $display("FAIL sat_total got %0d, expected 19", total_votes); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int nv, first, v0;
        v0 = vld_seen;
        button = 4'b0001;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        button = '0;
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        for (int i = 0; i < NC; i++) exp_cnt[i] = 0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (vld_seen !== v0) $display("FAIL rstmid_no_vote got %0d pulses, expected 0", vld_seen - v0);
        else n_pass++;
        n_checks++;
        if ({total_votes, winner_valid, tie} !== '0)
            $display("FAIL rstmid_cleared got total=%0d v=%b tie=%b, expected 0 0 0", total_votes, winner_valid, tie);
        else n_pass++;
        expect_vote(0);
        press(4'b0001, 8, 6, nv, first);
        n_checks++;
        if (first !== DB + 1) $display("FAIL rstmid_fresh_latency got %0d, expected %0d", first, DB + 1);
        else n_pass++;
        n_checks++;
        if (total_votes !== 6'd1) $display("FAIL rstmid_total got %0d, expected 1", total_votes); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < NC; i++) exp_cnt[i] = 0;
        @(negedge clk);
        test_reset();
        test_clean_votes();
        test_glitch();
        test_reject();
        test_tie();
        test_display();
        test_saturate();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL sb_drain got %0d pending, expected 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
